// File: rtl/psum_accum.sv
// Vertical partial-sum accumulator: sums ROWS consecutive PE psum rows lane-wise
// with signed saturation, then holds the completed row on a valid/ready output.
module psum_accum #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 5,
  parameter int unsigned ROWS  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_psum,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_psum,
  output logic [2:0]         row_cnt,
  output logic [7:0]         out_cnt,
  output logic               sat_flag
);

  localparam int unsigned BW = LANES * W;

  typedef enum logic {ACC, HOLD} state_t;

  state_t        state;
  logic [BW-1:0] acc;
  logic [BW-1:0] next_row;
  logic          sat_any;
  logic [W-1:0]  lane_a;
  logic [W-1:0]  lane_b;
  logic [W:0]    lane_sum;
  logic          in_take;
  logic          out_take;
  logic          completing;

  assign out_valid  = (state == HOLD);
  assign in_ready   = !rst && !flush && (!out_valid || out_ready);
  assign in_take    = in_valid && in_ready;
  assign out_take   = out_valid && out_ready;
  assign completing = in_take && (row_cnt == 3'(ROWS - 1));

  // Lane-wise next accumulation: first row loads, later rows add at W+1 bits and clamp.
  always_comb begin
    next_row = '0;
    sat_any  = 1'b0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_a   = acc[i*W +: W];
      lane_b   = in_psum[i*W +: W];
      lane_sum = {lane_a[W-1], lane_a} + {lane_b[W-1], lane_b};
      if (row_cnt == 3'd0) begin
        next_row[i*W +: W] = lane_b;
      end else if (lane_sum[W] != lane_sum[W-1]) begin
        sat_any            = 1'b1;
        next_row[i*W +: W] = lane_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        next_row[i*W +: W] = lane_sum[W-1:0];
      end
    end
  end

  // FSM, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      out_psum <= '0;
      row_cnt  <= 3'd0;
      out_cnt  <= 8'd0;
      sat_flag <= 1'b0;
    end else begin
      if (flush) begin
        row_cnt <= 3'd0;
      end else if (in_take) begin
        acc <= next_row;
        if (completing) begin
          row_cnt  <= 3'd0;
          out_psum <= next_row;
        end else begin
          row_cnt <= row_cnt + 3'd1;
        end
      end

      case (state)
        ACC:     if (completing) state <= HOLD;
        HOLD:    if (out_take && !completing) state <= ACC;
        default: state <= ACC;
      endcase

      if (out_take) out_cnt <= out_cnt + 8'd1;
      if (in_take && sat_any) sat_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: default 3-row instance plus a ROWS=1 echo instance.
module tb_psum_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [79:0] in_psum;
  logic        in_ready, out_valid, sat_flag;
  logic [79:0] out_psum;
  logic [2:0]  row_cnt;
  logic [7:0]  out_cnt;

  logic        in_valid1;
  logic [79:0] in_psum1;
  logic        in_ready1, out_valid1, sat_flag1;
  logic [79:0] out_psum1;
  logic [2:0]  row_cnt1;
  logic [7:0]  out_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  psum_accum #(.W(16), .LANES(5), .ROWS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
    .row_cnt(row_cnt), .out_cnt(out_cnt), .sat_flag(sat_flag)
  );

  psum_accum #(.W(16), .LANES(5), .ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_psum(in_psum1),
    .flush(1'b0), .out_valid(out_valid1), .out_ready(1'b1), .out_psum(out_psum1),
    .row_cnt(row_cnt1), .out_cnt(out_cnt1), .sat_flag(sat_flag1)
  );

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] p5(input int a, input int b, input int c, input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [79:0] row);
    in_valid = 1'b1;
    in_psum  = row;
    tick();
    in_valid = 1'b0;
  endtask

  logic [79:0] echo_tab [4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_psum = '0;
    in_valid1 = 1'b0; in_psum1 = '0;
    tick();
    check("rst_in_ready", 80'(in_ready), 80'd0);
    tick();
    check("rst_out_valid", 80'(out_valid), 80'd0);
    check("rst_out_psum", out_psum, 80'd0);
    check("rst_row_cnt", 80'(row_cnt), 80'd0);
    check("rst_out_cnt", 80'(out_cnt), 80'd0);
    check("rst_sat", 80'(sat_flag), 80'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 80'(in_ready), 80'd1);

    // basic three-row accumulation
    send(p5(1, 2, 3, 4, 5));
    check("row_cnt_1", 80'(row_cnt), 80'd1);
    send(p5(10, 20, 30, 40, 50));
    check("row_cnt_2", 80'(row_cnt), 80'd2);
    check("no_early_valid", 80'(out_valid), 80'd0);
    send(p5(100, 200, 300, 400, 500));
    check("basic_valid", 80'(out_valid), 80'd1);
    check("basic_psum", out_psum, p5(111, 222, 333, 444, 555));
    check("basic_row_cnt", 80'(row_cnt), 80'd0);
    tick();
    check("basic_out_cnt", 80'(out_cnt), 80'd1);
    check("basic_taken", 80'(out_valid), 80'd0);
    check("basic_sat", 80'(sat_flag), 80'd0);

    // saturation both directions
    send(p5(30000, -20000, 0, 0, 0));
    send(p5(30000, -20000, 0, 0, 0));
    check("sat_set", 80'(sat_flag), 80'd1);
    send(p5(30000, -20000, 0, 0, 0));
    check("sat_psum", out_psum, p5(32767, -32768, 0, 0, 0));
    tick();
    check("sat_out_cnt", 80'(out_cnt), 80'd2);

    // backpressure: result held, input blocked
    out_ready = 1'b0;
    send(p5(1, 1, 1, 1, 1));
    send(p5(1, 1, 1, 1, 1));
    send(p5(1, 1, 1, 1, 1));
    in_valid = 1'b1;
    in_psum  = p5(7, 7, 7, 7, 7);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 80'(out_valid), 80'd1);
      check("bp_in_ready", 80'(in_ready), 80'd0);
      check("bp_psum", out_psum, p5(3, 3, 3, 3, 3));
      tick();
    end
    check("bp_row_cnt", 80'(row_cnt), 80'd0);
    check("bp_out_cnt", 80'(out_cnt), 80'd2);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 80'(in_ready), 80'd1);
    tick();
    in_valid = 1'b0;
    check("bp_release_cnt", 80'(out_cnt), 80'd3);
    check("bp_release_row", 80'(row_cnt), 80'd1);
    check("bp_release_valid", 80'(out_valid), 80'd0);
    send(p5(1, 2, 3, 4, 5));
    send(p5(1, 2, 3, 4, 5));
    check("bp_next_psum", out_psum, p5(9, 11, 13, 15, 17));
    tick();
    check("sat_sticky", 80'(sat_flag), 80'd1);

    // flush drops partial and blocks a same-cycle beat
    send(p5(50, 50, 50, 50, 50));
    send(p5(60, 60, 60, 60, 60));
    flush = 1'b1; in_valid = 1'b1; in_psum = p5(70, 70, 70, 70, 70);
    #1;
    check("flush_in_ready", 80'(in_ready), 80'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_row_cnt", 80'(row_cnt), 80'd0);
    send(p5(1, 2, 3, 4, 5));
    send(p5(1, 2, 3, 4, 5));
    send(p5(1, 2, 3, 4, 5));
    check("flush_psum", out_psum, p5(3, 6, 9, 12, 15));
    tick();
    check("flush_out_cnt", 80'(out_cnt), 80'd5);

    // reset mid-accumulation
    send(p5(100, 100, 100, 100, 100));
    send(p5(100, 100, 100, 100, 100));
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 80'(in_ready), 80'd0);
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 80'(out_valid), 80'd0);
    check("mid_rst_psum", out_psum, 80'd0);
    check("mid_rst_row", 80'(row_cnt), 80'd0);
    check("mid_rst_cnt", 80'(out_cnt), 80'd0);
    check("mid_rst_sat", 80'(sat_flag), 80'd0);
    send(p5(1, 2, 3, 4, 5));
    send(p5(10, 20, 30, 40, 50));
    send(p5(-5, 0, 5, 0, -1));
    check("post_rst_psum", out_psum, p5(6, 22, 38, 44, 54));
    tick();
    tick();
    check("post_rst_one_out", 80'(out_cnt), 80'd1);
    check("post_rst_idle", 80'(out_valid), 80'd0);

    // out_cnt wrap with back-to-back groups
    for (int g = 0; g < 255; g++) begin
      send(80'd0);
      send(80'd0);
      send(80'd0);
    end
    check("wrap_pre", 80'(out_cnt), 80'd255);
    check("wrap_valid", 80'(out_valid), 80'd1);
    tick();
    check("wrap_zero", 80'(out_cnt), 80'd0);

    // ROWS=1 echo, no saturation applied
    echo_tab[0] = p5(1, 2, 3, 4, 5);
    echo_tab[1] = p5(32767, 32767, -32768, -32768, 0);
    echo_tab[2] = p5(-1, 0, 1, 100, -100);
    echo_tab[3] = p5(30000, 30000, 30000, 30000, 30000);
    check("echo_idle", 80'(out_valid1), 80'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid1 = 1'b1;
      in_psum1  = echo_tab[i];
      tick();
      check("echo_valid", 80'(out_valid1), 80'd1);
      check("echo_psum", out_psum1, echo_tab[i]);
    end
    in_valid1 = 1'b0;
    tick();
    check("echo_cnt", 80'(out_cnt1), 80'd4);
    check("echo_sat", 80'(sat_flag1), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
